// File: rtl/de_scoreboard.sv
// Register-hazard scoreboard for the decode stage: one pending-write counter per
// architectural register, released by any number of writeback and squash ports.
module de_scoreboard #(
  parameter int unsigned NREGS      = 32,
  parameter int unsigned REGNOBITS  = 5,
  parameter int unsigned CNTW       = 2,
  parameter int unsigned NUM_WB     = 1,
  parameter int unsigned NUM_CANCEL = 1,
  parameter int unsigned WB_BYPASS  = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             issue_valid,
  input  logic [REGNOBITS-1:0]             rs1,
  input  logic                             use_rs1,
  input  logic [REGNOBITS-1:0]             rs2,
  input  logic                             use_rs2,
  input  logic [REGNOBITS-1:0]             rd,
  input  logic                             wr_reg,
  input  logic                             ext_stall,
  input  logic [NUM_WB-1:0]                wb_valid,
  input  logic [NUM_WB*REGNOBITS-1:0]      wb_regno,
  input  logic [NUM_CANCEL-1:0]            cancel_valid,
  input  logic [NUM_CANCEL*REGNOBITS-1:0]  cancel_regno,
  output logic                             stall_out,
  output logic                             issue_fire,
  output logic [NREGS-1:0]                 busy_vec,
  output logic                             err_underflow
);

  localparam int unsigned RELW = $clog2(NUM_WB + NUM_CANCEL + 1);
  localparam int unsigned SUMW = CNTW + RELW + 1;
  localparam logic [CNTW-1:0] CntMax = '1;

  logic [CNTW-1:0]  cnt_q [NREGS];
  logic [CNTW-1:0]  cnt_d [NREGS];
  logic [RELW-1:0]  rel   [NREGS];
  logic [NREGS-1:0] busy_eff;
  logic [NREGS-1:0] inc;
  logic [SUMW-1:0]  sum;
  logic             rs1_busy, rs2_busy, rd_full;
  logic             hazard, full;
  logic             err_q, err_d;

  // Count releases per register; r0 and out-of-range indices never match.
  always_comb begin
    for (int unsigned r = 0; r < NREGS; r++) rel[r] = '0;
    for (int unsigned p = 0; p < NUM_WB; p++) begin
      for (int unsigned r = 1; r < NREGS; r++) begin
        if (wb_valid[p] && wb_regno[p*REGNOBITS +: REGNOBITS] == REGNOBITS'(r)) begin
          rel[r] = rel[r] + RELW'(1);
        end
      end
    end
    for (int unsigned p = 0; p < NUM_CANCEL; p++) begin
      for (int unsigned r = 1; r < NREGS; r++) begin
        if (cancel_valid[p] && cancel_regno[p*REGNOBITS +: REGNOBITS] == REGNOBITS'(r)) begin
          rel[r] = rel[r] + RELW'(1);
        end
      end
    end
  end

  always_comb begin
    for (int unsigned r = 0; r < NREGS; r++) begin
      if (WB_BYPASS != 0) begin
        busy_eff[r] = SUMW'(cnt_q[r]) > SUMW'(rel[r]);
      end else begin
        busy_eff[r] = cnt_q[r] != '0;
      end
    end
  end

  always_comb begin
    rs1_busy = 1'b0;
    rs2_busy = 1'b0;
    rd_full  = 1'b0;
    for (int unsigned r = 0; r < NREGS; r++) begin
      if (rs1 == REGNOBITS'(r)) rs1_busy = busy_eff[r];
      if (rs2 == REGNOBITS'(r)) rs2_busy = busy_eff[r];
      if (rd == REGNOBITS'(r))  rd_full  = cnt_q[r] == CntMax;
    end
  end

  assign hazard     = issue_valid & ((use_rs1 & (rs1 != '0) & rs1_busy) |
                                     (use_rs2 & (rs2 != '0) & rs2_busy));
  assign full       = issue_valid & wr_reg & (rd != '0) & rd_full;
  assign stall_out  = ext_stall | hazard | full;
  assign issue_fire = issue_valid & ~stall_out;

  always_comb begin
    for (int unsigned r = 0; r < NREGS; r++) begin
      inc[r] = issue_fire & wr_reg & (rd == REGNOBITS'(r)) & (r != 0);
    end
  end

  always_comb begin
    err_d = err_q;
    sum   = '0;
    for (int unsigned r = 0; r < NREGS; r++) begin
      sum = SUMW'(cnt_q[r]) + SUMW'(inc[r]) - SUMW'(rel[r]);
      if (sum[SUMW-1]) begin
        cnt_d[r] = '0;
        err_d    = 1'b1;
      end else if (sum[SUMW-2:CNTW] != '0) begin
        // Unreachable while full blocks issue at the maximum count.
        cnt_d[r] = CntMax;
      end else begin
        cnt_d[r] = sum[CNTW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned r = 0; r < NREGS; r++) cnt_q[r] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < NREGS; r++) cnt_q[r] <= cnt_d[r];
      err_q <= err_d;
    end
  end

  always_comb begin
    for (int unsigned r = 0; r < NREGS; r++) busy_vec[r] = cnt_q[r] != '0;
  end

  assign err_underflow = err_q;

endmodule

// File: doc/de_scoreboard.md
# de_scoreboard

Parametrised register-hazard scoreboard for the decode (DE) stage of the pipelined RISC-V core. It replaces the single in-use bit per register with a small pending-write counter per architectural register. This keeps several in-flight writers to the same destination correct: a WAW pair no longer clears the hazard early. It accepts any number of writeback release ports and squash (cancel) release ports. DE drives it with the decoded source/destination fields of the instruction at the head of DE. Its stall output goes to FE and gates the DE latch.

## Interface
- NREGS, 32, number of architectural registers; register 0 is hardwired zero and is never tracked.
- REGNOBITS, 5, register index width; must satisfy 2^REGNOBITS >= NREGS.
- CNTW, 2, width of each pending-write counter; maximum in-flight writes per register = 2^CNTW-1.
- NUM_WB, 1, number of writeback release ports.
- NUM_CANCEL, 1, number of squash release ports.
- WB_BYPASS, 0, 1 = a release in the current cycle that drains a counter to zero removes the hazard in that same cycle.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low; clears all state while low.
- issue_valid  input  1  a valid instruction is presented in DE.
- rs1  input  REGNOBITS  source 1 index.
- use_rs1  input  1  instruction reads rs1.
- rs2  input  REGNOBITS  source 2 index.
- use_rs2  input  1  instruction reads rs2.
- rd  input  REGNOBITS  destination index.
- wr_reg  input  1  instruction writes rd.
- ext_stall  input  1  external stall request, e.g. branch mispredict from AGEX.
- wb_valid  input  NUM_WB  per-port writeback release.
- wb_regno  input  NUM_WB*REGNOBITS  per-port released register; port i occupies bits [i*REGNOBITS +: REGNOBITS].
- cancel_valid  input  NUM_CANCEL  per-port release for a squashed in-flight writer.
- cancel_regno  input  NUM_CANCEL*REGNOBITS  per-port released register.
- stall_out  output  1  DE must hold and insert a bubble.
- issue_fire  output  1  instruction leaves DE this cycle.
- busy_vec  output  NREGS  bit r = counter r nonzero (registered view); bit 0 is always 0.
- err_underflow  output  1  sticky; a release arrived for a register whose count was already exhausted.

## Operation
- State: cnt[r] (CNTW bits) for r = 1..NREGS-1, plus the err_underflow flag. cnt[0] reads as 0.
- rel[r] = number of asserted wb and cancel ports whose regno equals r, with r != 0. Releases to r0 are ignored. Several ports may name the same r in one cycle; each one counts.
- busy_eff[r]:
  - WB_BYPASS=0: busy_eff[r] = (cnt[r] != 0).
  - WB_BYPASS=1: busy_eff[r] = (cnt[r] > rel[r]).
- hazard = issue_valid & ((use_rs1 & rs1!=0 & busy_eff[rs1]) | (use_rs2 & rs2!=0 & busy_eff[rs2])).
- full = issue_valid & wr_reg & rd!=0 & (cnt[rd] == 2^CNTW-1). This is a structural stall.
- stall_out = ext_stall | hazard | full. This is combinational and is asserted even when issue_valid=0 if ext_stall=1.
- issue_fire = issue_valid & ~stall_out.
- inc[r] = issue_fire & wr_reg & rd==r & r!=0.
- Next state: cnt[r] <= cnt[r] + inc[r] - rel[r], computed at CNTW+$clog2(NUM_WB+NUM_CANCEL+1)+1 bits.
  - If the result would be negative, cnt[r] <= 0 and err_underflow <= 1.
  - Increment and release to the same register in the same cycle net against each other.
- err_underflow clears only on reset.
- Out-of-range indices (>= NREGS) are ignored on every port.

## Timing
- Reset low: all cnt = 0 and err_underflow = 0 asynchronously. busy_vec = 0 immediately. stall_out = ext_stall.
- Reset deasserting takes effect on the next rising edge. A reset asserted mid-operation discards all pending counts; the pipeline must also be flushed.
- Issue to busy latency: an instruction that fires in cycle N sets busy_vec[rd] after the edge ending cycle N. A dependent instruction in cycle N+1 stalls.
- Release to clear latency:
  - WB_BYPASS=0: release in cycle N clears the hazard in cycle N+1.
  - WB_BYPASS=1: the hazard clears in cycle N itself, combinationally.
- The register file write happens on the falling edge, so WB_BYPASS=1 is legal only when the read value is also bypassed.
- No handshake on the release ports; each asserted cycle is exactly one release.

## Test plan
- After reset, issue `add x5` then `addi x6,x5,1` back to back → the second instruction stalls. busy_vec[5]=1 until wb_valid with regno 5. With WB_BYPASS=0 it fires the cycle after the release; with WB_BYPASS=1 it fires in the same cycle.
- WAW: fire two writers to x7, then release one → busy_vec[7] stays 1 and the reader of x7 still stalls. After the second release, busy_vec[7]=0.
- CNTW=2: fire 3 writers to x9 → a 4th writer of x9 sees full=1 and stall_out=1. Release x9 once → the next cycle the 4th writer fires and cnt[9] returns to 3.
- Same-cycle increment and release to x4 (cnt=1) → cnt[4] stays 1 and err_underflow stays 0. Release x4 with cnt=0 → err_underflow=1 and it holds until reset.
- Writer and reader to x0, plus release of x0 → never a stall, busy_vec[0]=0. ext_stall=1 with issue_valid=0 → stall_out=1, issue_fire=0, counters unchanged.
- NUM_WB=2, NUM_CANCEL=1: three releases to x3 (cnt=3) in one cycle → cnt[3]=0 the next cycle. Pull reset low mid-stream → busy_vec=0 immediately.
